// File: rtl/pri_request_latch.sv
// pri_request_latch: captures 16 request lines into pending flags and
// presents the highest-priority unmasked one with a valid/ack handshake.
module pri_request_latch #(
  parameter int unsigned EDGE_MODE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req_in,
  input  logic [15:0] mask,
  input  logic        enable,
  input  logic        irq_ack,
  output logic        irq_valid,
  output logic [3:0]  irq_id,
  output logic [15:0] pending
);

  localparam int unsigned N_SRC = 16;
  localparam int unsigned ID_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] pending_d;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  id_d;
  logic             valid_d;

  // Input synchroniser stage; req_in is never used before this register
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else begin
      req_q <= req_in;
    end
  end

  // Capture condition: rising edge of req_q or plain level
  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [N_SRC-1:0] req_qq;

      // Previous req_q, used to detect 0->1 transitions
      always_ff @(posedge clk) begin
        if (reset) begin
          req_qq <= '0;
        end else begin
          req_qq <= req_q;
        end
      end

      assign set_vec = req_q & ~req_qq;
    end else begin : g_level
      assign set_vec = req_q;
    end
  endgenerate

  assign eligible = pending & ~mask;

  // Priority encoder: highest set index of the eligible vector wins
  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  // Next-state and output logic; presented request is frozen while PRESENT
  always_comb begin
    state_d = state_q;
    valid_d = irq_valid;
    id_d    = irq_id;
    clr_vec = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && (eligible != '0)) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          id_d    = win_id;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          state_d         = GAP;
          valid_d         = 1'b0;
          clr_vec[irq_id] = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // A new capture in the same cycle as the acknowledge clear keeps the bit set
  assign pending_d = (pending & ~clr_vec) | set_vec;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending   <= '0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      state_q   <= state_d;
      pending   <= pending_d;
      irq_valid <= valid_d;
      irq_id    <= id_d;
    end
  end

endmodule
